mem_stall_bridge: RTL

Parametrised data-memory bridge between the pipeline's M-stage memory port and a synchronous single-port RAM with configurable read latency. It replaces the fixed one-cycle, inverted-clock RAM hookup with a handshaked access. It stalls the pipeline until the access completes, performs byte-lane steering for stores, and performs sign/zero extension for loads. It sits in the top level between `mips` and `data_mem`.

---
 rtl/mem_bridge_pkg.sv | 39 +++
 rtl/load_extend.sv | 25 ++
 rtl/mem_stall_bridge.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared encodings and byte-lane helpers for the data-memory bridges.
package mem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Reserved size 2'b11 falls into the word branches below.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: lane_data = {4{wdata[7:0]}};
            SZ_HALF: lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select plus sign/zero extension; shared by the data and instruction bridges.
module load_extend
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        zero_ext,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{~zero_ext & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{~zero_ext & lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stall_bridge.sv
// Handshaked M-stage to synchronous RAM bridge with pipeline stall and load extension.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err.
module mem_stall_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cap_size;
    logic [1:0]       cap_off;
    logic             cap_zext;
    logic             bad;
    logic             issue;
    logic [31:0]      ext_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad = misaligned(req_size, req_addr[1:0]);
`else
    assign bad = 1'b0;
`endif

    assign issue = rst & req_en & (state == ST_IDLE);
    assign stall = req_en & (state != ST_DONE);

    // RAM side is driven straight from the request so the access issues in the request cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (issue && !bad) begin
            ram_en    = 1'b1;
            ram_we    = req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
            ram_addr  = {req_addr[ADDR_W-1:2], 2'b00};
            ram_wdata = req_we ? lane_data(req_size, req_wdata) : '0;
        end
    end

    load_extend u_load_extend (
        .size     (cap_size),
        .offset   (cap_off),
        .zero_ext (cap_zext),
        .rdata    (ram_rdata),
        .data     (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cap_size   <= '0;
            cap_off    <= '0;
            cap_zext   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_en) begin
                        cap_size <= req_size;
                        cap_off  <= req_addr[1:0];
                        cap_zext <= req_unsigned;
                        if (bad || req_we) begin
                            state      <= ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= bad;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        resp_rdata <= ext_data;
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
